spi_flash_slave: RTL and testbench
==================================

SPI_FLASH_SLAVE -- requirements
Module: spi_flash_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64, byte capacity of the emulated flash array (power of two, 16..256).
REQ-002 SHALL have parameter SPIBITWIDE, default 8, width of the byte-parallel SPI data lanes.
REQ-003 SHALL have port p_clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port p_reset, input, 1: synchronous, active-high reset, sampled on p_clk rising edge.
REQ-005 SHALL have port s_clk, input, 1: SPI clock from the controller, synchronous to p_clk.
REQ-006 SHALL have port s_css, input, 1: chip select, active low; one frame per low period.
REQ-007 SHALL have port s_mosi, input, SPIBITWIDE: byte from the controller, valid at each s_clk rise.
REQ-008 SHALL have port s_miso, output, SPIBITWIDE: registered read byte returned to the controller.
REQ-009 SHALL have port frame_active, output, 1: high while a frame is being decoded (state not IDLE).
REQ-010 SHALL have port cmd_err, output, 1: one-p_clk pulse on an unsupported command byte.

Function
REQ-011 SHALL register s_clk each cycle; s_clk rise = s_clk high and registered copy low; all byte transfers occur only on the p_clk edge that detects a rise.
REQ-012 SHALL use states IDLE, CMD, ADDR, DATA, SKIP.
REQ-013 IDLE -> CMD when s_css low; CMD/ADDR/DATA/SKIP -> IDLE on any cycle s_css high.
REQ-014 CMD: on s_clk rise latch s_mosi as command; 0x02 (write) or 0x01 (read) -> ADDR; any other -> SKIP with cmd_err pulsed on the following cycle.
REQ-015 ADDR: three s_clk rises load 24-bit address MSB first (bits 23:16, 15:8, 7:0), then -> DATA.
REQ-016 Array index = address modulo MEM_DEPTH; upper address bits ignored (aliasing permitted).
REQ-017 DATA, write: each s_clk rise stores s_mosi at index, then index increments.
REQ-018 DATA, read: each s_clk rise loads s_miso with byte at index (visible next cycle), then index increments.
REQ-019 Index wraps from MEM_DEPTH-1 to 0 with no error indication.
REQ-020 SKIP: s_clk rises ignored; array and s_miso unchanged until s_css high.
REQ-021 s_css high and s_clk rise in same cycle: s_css wins, byte discarded, -> IDLE.
REQ-022 Frame aborted mid-ADDR: no array write; bytes already written in DATA remain.
REQ-023 s_miso holds last value between reads and after frame end.

Reset
REQ-024 On p_reset: state IDLE, s_miso 0, frame_active 0, cmd_err 0, address/index 0, write-enable latch 0.
REQ-025 Array contents not cleared by reset; reset mid-frame aborts the frame exactly as REQ-022.

Configuration
REQ-026 With SPI_FLASH_WEL_EN defined: command 0x06 sets write-enable latch (frame -> SKIP, no cmd_err); 0x02 writes only if latch set, else data bytes discarded; latch cleared when any 0x02 frame ends.
REQ-027 Without SPI_FLASH_WEL_EN: no latch; 0x06 is unsupported (cmd_err); 0x02 always writes.

Structure
REQ-028 Package spi_flash_pkg SHALL hold command constants (0x01, 0x02, 0x06), state enum, SPIBITWIDE default.
REQ-029 Byte array SHALL be sub-module spi_flash_mem: MEM_DEPTH x SPIBITWIDE, one sync write port, one sync read port.
REQ-030 FSM, edge detect, index counter in spi_flash_slave; RTL total 120-400 lines.

Verification
REQ-031 Frame 02,00,00,00,FF,00,FF,00 then frame 01,00,00,00 + 4 clocks -> s_miso FF,00,FF,00 in order.
REQ-032 Write frame at address 0x00003F with AA,55 -> read at 0x3F returns AA, read at 0x00 returns 55 (wrap).
REQ-033 Command 0x9F followed by 4 bytes -> cmd_err one cycle high, array unchanged, frame_active low after s_css high.
REQ-034 s_css raised after 2 address bytes of write frame, then full read of target -> old data returned.
REQ-035 p_reset during read frame DATA -> s_miso 0, IDLE next cycle; prior written data still readable.
REQ-036 SPI_FLASH_WEL_EN: 02 frame without 06 -> no write; 06 frame then 02 frame -> write lands; second 02 -> no write.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared constants, state enum and command decode
// for the byte-parallel SPI flash emulator (spi_flash_slave).
// Optional build macro: SPI_FLASH_WEL_EN (write-enable latch, cmd 0x06).
package spi_flash_pkg;

    localparam int SPIBITWIDE_DEF = 8;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_WREN  = 8'h06;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        SKIP
    } state_t;

    // Commands that do not raise cmd_err.
    function automatic logic cmd_known(input logic [7:0] c);
`ifdef SPI_FLASH_WEL_EN
        return (c == CMD_READ) || (c == CMD_WRITE) || (c == CMD_WREN);
`else
        return (c == CMD_READ) || (c == CMD_WRITE);
`endif
    endfunction

endpackage

// File: rtl/spi_flash_mem.sv
// spi_flash_mem: DEPTH x WIDTH byte array, one sync write, one sync read.
// Ports: clk, rst (clears read register only), we/waddr/wdata, re/raddr/rdata.
module spi_flash_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_flash_slave.sv
// spi_flash_slave: byte-parallel SPI flash emulator (read 0x01, write 0x02,
// 24-bit address, index wraps modulo MEM_DEPTH). Optional: SPI_FLASH_WEL_EN.
// Ports: p_clk, p_reset (sync, active high), s_clk, s_css (active low),
//        s_mosi, s_miso (registered read byte), frame_active, cmd_err.
module spi_flash_slave
    import spi_flash_pkg::*;
#(
    parameter int MEM_DEPTH  = 64,
    parameter int SPIBITWIDE = SPIBITWIDE_DEF
) (
    input  logic                  p_clk,
    input  logic                  p_reset,
    input  logic                  s_clk,
    input  logic                  s_css,
    input  logic [SPIBITWIDE-1:0] s_mosi,
    output logic [SPIBITWIDE-1:0] s_miso,
    output logic                  frame_active,
    output logic                  cmd_err
);

    localparam int AW = $clog2(MEM_DEPTH);

    state_t         state;
    state_t         state_nx;
    logic           s_clk_q;
    logic           rise;
    logic           xfer;
    logic [7:0]     mosi_b;
    logic           is_wr;
    logic [1:0]     abyte;
    logic [AW-1:0]  idx;
    logic           wel_ok;
    logic           mem_we;
    logic           mem_re;

    assign mosi_b = 8'(s_mosi);
    assign rise   = s_clk & ~s_clk_q;
    // Chip select high wins over a coincident s_clk rise.
    assign xfer   = rise & ~s_css;

    always_ff @(posedge p_clk) begin
        s_clk_q <= s_clk;
    end

    // State register.
    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!s_css) begin
                    state_nx = CMD;
                end
            end
            CMD: begin
                if (s_css) begin
                    state_nx = IDLE;
                end else if (xfer) begin
                    if (mosi_b == CMD_READ || mosi_b == CMD_WRITE) begin
                        state_nx = ADDR;
                    end else begin
                        state_nx = SKIP;
                    end
                end
            end
            ADDR: begin
                if (s_css) begin
                    state_nx = IDLE;
                end else if (xfer && abyte == 2'd2) begin
                    state_nx = DATA;
                end
            end
            DATA, SKIP: begin
                if (s_css) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output / strobe logic.
    always_comb begin
        frame_active = (state != IDLE);
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        if (state == DATA && xfer) begin
            mem_we = is_wr & wel_ok;
            mem_re = ~is_wr;
        end
    end

    // Command flag, address byte counter, array index, error pulse.
    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            is_wr   <= 1'b0;
            abyte   <= 2'd0;
            idx     <= '0;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= (state == CMD) && xfer && !cmd_known(mosi_b);
            unique case (state)
                IDLE: begin
                    is_wr <= 1'b0;
                    abyte <= 2'd0;
                end
                CMD: begin
                    if (xfer) begin
                        is_wr <= (mosi_b == CMD_WRITE);
                    end
                end
                ADDR: begin
                    // MEM_DEPTH <= 256, so only the low address byte
                    // contributes to the index; earlier bytes alias away.
                    if (xfer) begin
                        idx   <= mosi_b[AW-1:0];
                        abyte <= abyte + 2'd1;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        idx <= idx + 1'b1;
                    end
                end
                SKIP: begin
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SPI_FLASH_WEL_EN
    logic wel;

    // Any 0x02 frame consumes the latch when it ends.
    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            wel <= 1'b0;
        end else if (state == CMD && xfer && mosi_b == CMD_WREN) begin
            wel <= 1'b1;
        end else if (state != IDLE && s_css && is_wr) begin
            wel <= 1'b0;
        end
    end

    assign wel_ok = wel;
`else
    assign wel_ok = 1'b1;
`endif

    spi_flash_mem #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (SPIBITWIDE),
        .AW    (AW)
    ) u_mem (
        .clk   (p_clk),
        .rst   (p_reset),
        .we    (mem_we),
        .waddr (idx),
        .wdata (s_mosi),
        .re    (mem_re),
        .raddr (idx),
        .rdata (s_miso)
    );

endmodule

// File: tb/tb_spi_flash_slave.sv
// tb_spi_flash_slave: frame-level reference model + directed and random frames.
// Optional build macro: SPI_FLASH_WEL_EN.
module tb_spi_flash_slave;

    localparam int DEPTH = 64;

    typedef logic [7:0] bq_t[$];

    logic       p_clk = 1'b0;
    logic       p_reset = 1'b1;
    logic       s_clk = 1'b0;
    logic       s_css = 1'b1;
    logic [7:0] s_mosi = 8'h00;
    logic [7:0] s_miso;
    logic       frame_active;
    logic       cmd_err;

    always #5 p_clk = ~p_clk;

    spi_flash_slave #(
        .MEM_DEPTH  (DEPTH),
        .SPIBITWIDE (8)
    ) dut (
        .p_clk        (p_clk),
        .p_reset      (p_reset),
        .s_clk        (s_clk),
        .s_css        (s_css),
        .s_mosi       (s_mosi),
        .s_miso       (s_miso),
        .frame_active (frame_active),
        .cmd_err      (cmd_err)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    endtask

    // ---------------- frame-level reference model ----------------
    logic [7:0] mm [DEPTH];
    logic       m_prev = 1'b0;
    bit         m_open = 0;
    bit         m_valid = 0;
    bit         m_wel = 0;
    int         m_n = 0;
    int         m_addr = 0;
    logic [7:0] m_cmd = 8'h00;
    logic [7:0] e_miso = 8'h00;
    logic       e_act = 1'b0;
    logic       e_err = 1'b0;
    int         err_pulses = 0;

    function automatic bit known(input logic [7:0] c);
`ifdef SPI_FLASH_WEL_EN
        return c == 8'h01 || c == 8'h02 || c == 8'h06;
`else
        return c == 8'h01 || c == 8'h02;
`endif
    endfunction

    // Byte k of a frame: 0 = command, 1..3 = address, 4.. = data.
    function automatic void model_byte(input logic [7:0] b);
        int off;
        bit wok;
`ifdef SPI_FLASH_WEL_EN
        wok = m_wel;
`else
        wok = 1;
`endif
        if (m_n == 0) begin
            m_cmd = b;
            if (!known(b)) e_err = 1'b1;
`ifdef SPI_FLASH_WEL_EN
            if (b == 8'h06) m_wel = 1;
`endif
        end else if (m_n <= 3) begin
            m_addr = (m_addr << 8) | int'(b);
            if (m_n == 1) m_addr = int'(b);
        end else begin
            off = (m_addr + m_n - 4) % DEPTH;
            if (m_cmd == 8'h01) e_miso = mm[off];
            else if (m_cmd == 8'h02 && wok) mm[off] = b;
        end
    endfunction

    logic       c_rs, c_css, c_sc, c_rise;
    logic [7:0] c_b;

    always @(posedge p_clk) begin
        c_rs = p_reset;
        c_css = s_css;
        c_sc = s_clk;
        c_b = s_mosi;
        c_rise = c_sc && !m_prev;
        m_prev = c_sc;
        e_err = 1'b0;
        if (c_rs) begin
            m_open = 0;
            m_wel = 0;
            e_miso = 8'h00;
            e_act = 1'b0;
            m_valid = 1;
        end else if (c_css) begin
            if (m_open && m_n > 0 && m_cmd == 8'h02) m_wel = 0;
            m_open = 0;
            e_act = 1'b0;
        end else if (!m_open) begin
            m_open = 1;
            m_n = 0;
            e_act = 1'b1;
        end else begin
            e_act = 1'b1;
            if (c_rise) begin
                model_byte(c_b);
                m_n++;
            end
        end
        #1;
        if (m_valid) begin
            check("miso", 32'(s_miso), 32'(e_miso));
            check("frame_active", 32'(frame_active), 32'(e_act));
            check("cmd_err", 32'(cmd_err), 32'(e_err));
        end
        if (cmd_err) err_pulses++;
    end

    // ---------------- drivers ----------------
    bq_t rxq;
    bit  collide = 0;

    task automatic sbyte(input logic [7:0] b, output logic [7:0] got);
        @(negedge p_clk);
        s_mosi = b;
        s_clk = 1'b1;
        @(negedge p_clk);
        s_clk = 1'b0;
        got = s_miso;
        repeat ($urandom_range(0, 2)) @(negedge p_clk);
    endtask

    task automatic frame(input bq_t tx);
        logic [7:0] g;
        rxq = {};
        @(negedge p_clk);
        s_css = 1'b0;
        foreach (tx[i]) begin
            sbyte(tx[i], g);
            rxq.push_back(g);
        end
        @(negedge p_clk);
        s_css = 1'b1;
        if (collide) begin
            s_clk = 1'b1;
            s_mosi = 8'($urandom);
            @(negedge p_clk);
            s_clk = 1'b0;
            collide = 0;
        end
        @(negedge p_clk);
    endtask

    task automatic wren();
        bq_t q;
        q = {8'h06};
        frame(q);
    endtask

    task automatic wr(input logic [23:0] a, input bq_t d);
        bq_t q;
`ifdef SPI_FLASH_WEL_EN
        wren();
`endif
        q = {8'h02, a[23:16], a[15:8], a[7:0]};
        foreach (d[i]) q.push_back(d[i]);
        frame(q);
    endtask

    task automatic rd(input logic [23:0] a, input int n);
        bq_t q;
        q = {8'h01, a[23:16], a[15:8], a[7:0]};
        repeat (n) q.push_back(8'($urandom));
        frame(q);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bq_t d;
        logic [7:0] g;
        int e0;

        repeat (3) @(negedge p_clk);
        check("rst_miso", 32'(s_miso), 32'h0);
        check("rst_active", 32'(frame_active), 32'h0);
        p_reset = 1'b0;
        @(negedge p_clk);

        // Fill the whole array so every later read is defined.
        d = {};
        repeat (DEPTH) d.push_back(8'($urandom));
        wr(24'h000000, d);

        // Write FF,00,FF,00 at 0 and read back.
        d = {8'hFF, 8'h00, 8'hFF, 8'h00};
        wr(24'h000000, d);
        rd(24'h000000, 4);
        check("rd0", 32'(rxq[4]), 32'hFF);
        check("rd1", 32'(rxq[5]), 32'h00);
        check("rd2", 32'(rxq[6]), 32'hFF);
        check("rd3", 32'(rxq[7]), 32'h00);

        // Index wrap from 0x3F to 0x00.
        d = {8'hAA, 8'h55};
        wr(24'h00003F, d);
        rd(24'h00003F, 1);
        check("wrap_3f", 32'(rxq[4]), 32'hAA);
        rd(24'h000000, 1);
        check("wrap_00", 32'(rxq[4]), 32'h55);

        // Upper address bits alias.
        rd(24'hA5C03F, 2);
        check("alias_3f", 32'(rxq[4]), 32'hAA);
        check("alias_00", 32'(rxq[5]), 32'h55);

        // Unsupported command: one pulse, array untouched.
        e0 = err_pulses;
        d = {8'h9F, 8'h00, 8'h00, 8'h00, 8'h77};
        frame(d);
        check("err_pulses", 32'(err_pulses - e0), 32'd1);
        check("err_inactive", 32'(frame_active), 32'h0);
        rd(24'h000000, 4);
        check("skip_keep0", 32'(rxq[4]), 32'h55);
        check("skip_keep1", 32'(rxq[5]), 32'h00);
        check("skip_keep2", 32'(rxq[6]), 32'hFF);
        check("skip_keep3", 32'(rxq[7]), 32'h00);

        // Write aborted after two address bytes.
`ifdef SPI_FLASH_WEL_EN
        wren();
`endif
        d = {8'h02, 8'h00, 8'h00};
        frame(d);
        rd(24'h000002, 1);
        check("abort_keep", 32'(rxq[4]), 32'hFF);

        // Reset in the middle of a read data phase.
        @(negedge p_clk);
        s_css = 1'b0;
        d = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        foreach (d[i]) sbyte(d[i], g);
        check("pre_rst_miso", 32'(g), 32'h55);
        p_reset = 1'b1;
        @(negedge p_clk);
        p_reset = 1'b0;
        s_css = 1'b1;
        check("rst_mid_miso", 32'(s_miso), 32'h0);
        check("rst_mid_active", 32'(frame_active), 32'h0);
        @(negedge p_clk);
        rd(24'h000000, 2);
        check("post_rst0", 32'(rxq[4]), 32'h55);
        check("post_rst1", 32'(rxq[5]), 32'h00);

`ifdef SPI_FLASH_WEL_EN
        d = {8'h33};
        wr(24'h000005, d);
        d = {8'h02, 8'h00, 8'h00, 8'h05, 8'h77};
        frame(d);
        rd(24'h000005, 1);
        check("wel_none", 32'(rxq[4]), 32'h33);
        wren();
        frame(d);
        rd(24'h000005, 1);
        check("wel_set", 32'(rxq[4]), 32'h77);
        d = {8'h02, 8'h00, 8'h00, 8'h05, 8'h99};
        frame(d);
        rd(24'h000005, 1);
        check("wel_used", 32'(rxq[4]), 32'h77);
`endif

        // Randomized frames: mixed commands, lengths, aborts, collisions.
        for (int it = 0; it < 60; it++) begin
            logic [7:0] c;
            int k;
            k = $urandom_range(0, 5);
            case (k)
                0, 1:    c = 8'h01;
                2, 3:    c = 8'h02;
                4:       c = 8'h06;
                default: c = 8'($urandom);
            endcase
`ifdef SPI_FLASH_WEL_EN
            if (c == 8'h02 && $urandom_range(0, 1) == 1) wren();
`endif
            d = {c, 8'($urandom), 8'($urandom), 8'($urandom)};
            repeat ($urandom_range(0, 8)) d.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, d.size() - 1);
                d = d[0:k];
            end
            collide = ($urandom_range(0, 3) == 0);
            frame(d);
        end

        // Final sweep of the array through the model.
        rd(24'h000000, DEPTH);

        repeat (3) @(negedge p_clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
